// File: rtl/assoc_cache_pkg.sv
// rtl/assoc_cache_pkg.sv - shared types and default geometry for the set-associative cache
package cache_types;

  typedef enum logic [1:0] {
    CHECK,
    WRITEBACK,
    FILL
  } state_t;

  localparam int DEF_S_OFFSET = 5;
  localparam int DEF_S_INDEX  = 3;
  localparam int DEF_NUM_WAYS = 2;
  localparam int DEF_S_TAG    = 32 - DEF_S_OFFSET - DEF_S_INDEX;
  localparam int DEF_S_LINE   = 8 * (2 ** DEF_S_OFFSET);

  typedef logic [DEF_S_LINE-1:0] line_t;

  // Way-select width; a direct-mapped cache still carries a 1-bit (always zero) way number.
  function automatic int way_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/assoc_cache_plru_tree.sv
// rtl/assoc_cache_plru_tree.sv - per-set tree pseudo-LRU state and victim selection
module plru_tree #(
  parameter int NUM_WAYS = 2,
  parameter int S_INDEX  = 3,
  localparam int WAY_W   = $clog2(NUM_WAYS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               touch_en,
  input  logic [WAY_W-1:0]   touch_way,
  input  logic [S_INDEX-1:0] index,
  output logic [WAY_W-1:0]   victim_way
);

  localparam int SETS  = 2 ** S_INDEX;
  localparam int NODES = NUM_WAYS - 1;

  logic [NODES-1:0] bits_q [SETS];
  logic [NODES-1:0] bits_d;

  // Node bit gives the direction of the victim subtree (0 = left); a touch points every
  // node on the path away from the touched way. Nodes are heap-ordered from the root.
  always_comb begin
    int               node;
    logic             dir;
    logic [NODES-1:0] sel;
    logic [NODES-1:0] one_hot;
    logic [WAY_W-1:0] tw;
    bits_d     = bits_q[index];
    victim_way = '0;
    node       = 0;
    for (int l = 0; l < WAY_W; l++) begin
      sel        = bits_q[index] >> node;
      dir        = sel[0];
      victim_way = (victim_way << 1) | WAY_W'(dir);
      node       = 2 * node + 1 + int'(dir);
    end
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      tw      = touch_way >> (WAY_W - 1 - l);
      dir     = tw[0];
      one_hot = NODES'(1) << node;
      bits_d  = dir ? (bits_d & ~one_hot) : (bits_d | one_hot);
      node    = 2 * node + 1 + int'(dir);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) bits_q[s] <= '0;
    end else if (touch_en) begin
      bits_q[index] <= bits_d;
    end
  end

endmodule

// File: rtl/assoc_cache.sv
// rtl/assoc_cache.sv - N-way set-associative write-back write-allocate cache, tree PLRU
// Defining ASSOC_CACHE_PERF_CNT_EN adds the hit/miss performance counters.
module assoc_cache
  import cache_types::*;
#(
  parameter int  S_OFFSET = DEF_S_OFFSET,
  parameter int  S_INDEX  = DEF_S_INDEX,
  parameter int  NUM_WAYS = DEF_NUM_WAYS,
  localparam int S_TAG    = 32 - S_OFFSET - S_INDEX,
  localparam int S_LINE   = 8 * (2 ** S_OFFSET)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [3:0]        mem_byte_enable,
  input  logic [31:0]       mem_address,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [S_LINE-1:0] pmem_wdata,
  input  logic [S_LINE-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int SETS  = 2 ** S_INDEX;
  localparam int WAY_W = way_bits(NUM_WAYS);
  localparam int BIT_W = S_OFFSET + 3;
  localparam logic [31:0]      OFF_MASK  = (32'd1 << S_OFFSET) - 32'd1;
  localparam logic [BIT_W-1:0] WORD_MASK = BIT_W'(OFF_MASK & ~32'd3);

  state_t           state_q, state_d;
  logic [WAY_W-1:0] victim_q, victim_d;

  logic              valid_q [NUM_WAYS][SETS];
  logic              dirty_q [NUM_WAYS][SETS];
  logic [S_TAG-1:0]  tag_q   [NUM_WAYS][SETS];
  logic [S_LINE-1:0] data_q  [NUM_WAYS][SETS];

  logic               req;
  logic [S_INDEX-1:0] idx;
  logic [S_TAG-1:0]   req_tag;
  logic [BIT_W-1:0]   bit_base;
  logic               hit;
  logic [WAY_W-1:0]   hit_way, miss_victim, plru_victim;
  logic [S_LINE-1:0]  hit_line;

  logic              arr_we, arr_dirty, touch_en;
  logic [WAY_W-1:0]  arr_way;
  logic [S_LINE-1:0] arr_line;

  assign req      = mem_read | mem_write;
  assign idx      = mem_address[S_OFFSET +: S_INDEX];
  assign req_tag  = mem_address[31 -: S_TAG];
  assign bit_base = (BIT_W'(mem_address) & WORD_MASK) << 3;
  assign hit_line = data_q[hit_way][idx];

  // Descending scan so the lowest-index invalid way wins the victim slot.
  always_comb begin
    hit         = 1'b0;
    hit_way     = '0;
    miss_victim = plru_victim;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[w][idx] && (tag_q[w][idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[w][idx]) miss_victim = WAY_W'(w);
    end
  end

  always_comb begin
    state_d      = state_q;
    victim_d     = victim_q;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    arr_we       = 1'b0;
    arr_way      = hit_way;
    arr_line     = hit_line;
    arr_dirty    = 1'b0;
    touch_en     = 1'b0;
    case (state_q)
      CHECK: begin
        if (req && hit) begin
          mem_resp  = 1'b1;
          touch_en  = 1'b1;
          mem_rdata = hit_line[bit_base +: 32];
          if (mem_write) begin
            arr_we    = 1'b1;
            arr_dirty = 1'b1;
            for (int b = 0; b < 4; b++) begin
              if (mem_byte_enable[b]) arr_line[bit_base + BIT_W'(b * 8) +: 8] = mem_wdata[b*8 +: 8];
            end
          end
        end else if (req) begin
          victim_d = miss_victim;
          state_d  = (valid_q[miss_victim][idx] && dirty_q[miss_victim][idx]) ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[victim_q][idx], idx, S_OFFSET'(0)};
        pmem_wdata   = data_q[victim_q][idx];
        if (pmem_resp) state_d = FILL;
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {req_tag, idx, S_OFFSET'(0)};
        if (pmem_resp) begin
          arr_we   = 1'b1;
          arr_way  = victim_q;
          arr_line = pmem_rdata;
          state_d  = CHECK;
        end
      end
      default: state_d = CHECK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= CHECK;
      victim_q <= '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[w][s] <= 1'b0;
          dirty_q[w][s] <= 1'b0;
        end
      end
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      if (arr_we) begin
        valid_q[arr_way][idx] <= 1'b1;
        dirty_q[arr_way][idx] <= arr_dirty;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && arr_we) begin
      tag_q[arr_way][idx]  <= req_tag;
      data_q[arr_way][idx] <= arr_line;
    end
  end

  generate
    if (NUM_WAYS > 1) begin : g_plru
      plru_tree #(
        .NUM_WAYS(NUM_WAYS),
        .S_INDEX (S_INDEX)
      ) u_plru (
        .clk       (clk),
        .rst       (rst),
        .touch_en  (touch_en),
        .touch_way (hit_way),
        .index     (idx),
        .victim_way(plru_victim)
      );
    end else begin : g_no_plru
      assign plru_victim = '0;
    end
  endgenerate

`ifdef ASSOC_CACHE_PERF_CNT_EN
  logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;
  logic        retry_q, retry_d;
  logic        lookup_hit, lookup_miss;

  assign lookup_hit  = (state_q == CHECK) && req && hit;
  assign lookup_miss = (state_q == CHECK) && req && !hit;

  // retry_q marks the re-lookup after a fill so it is not counted as a fresh hit.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    retry_d      = retry_q;
    if (lookup_hit) begin
      if (!retry_q) hit_count_d = hit_count_q + 32'd1;
      retry_d = 1'b0;
    end
    if (lookup_miss) begin
      if (!retry_q) miss_count_d = miss_count_q + 32'd1;
      retry_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
      retry_q      <= 1'b0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      retry_q      <= retry_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_assoc_cache.sv
// tb/tb_assoc_cache.sv - scoreboard bench for assoc_cache with a latency-modelled line memory
module tb_assoc_cache;
  import cache_types::*;

  localparam int LAT    = 2;
  localparam int BUDGET = 60;
  localparam int CLEAN  = LAT + 2;
  localparam int DIRTY  = 2 * LAT + 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [3:0]  mem_byte_enable = 4'h0;
  logic [31:0] mem_address = 32'h0, mem_wdata = 32'h0;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        pmem_read, pmem_write;
  logic [31:0] pmem_address;
  line_t       pmem_wdata;
  line_t       pmem_rdata = '0;
  logic        pmem_resp = 1'b0;
  logic [31:0] hit_count, miss_count;

  always #5 clk = ~clk;

  assoc_cache dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  int          vectors = 0;
  int          miscompares = 0;
  int          n_fill = 0;
  int          last_lat = 0;
  logic [31:0] exp_q [$];
  line_t       mem_lines [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  bit          log_wr [$];
  logic [31:0] log_addr [$];
  line_t       log_data [$];

  function automatic line_t pattern(input logic [31:0] a);
    line_t l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = {a[15:0] + 16'(i), 16'hC0DE ^ 16'(i * 37)};
    return l;
  endfunction

  function automatic line_t line_of(input logic [31:0] la);
    return mem_lines.exists(la) ? mem_lines[la] : pattern(la);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] wa;
    line_t l;
    wa = {a[31:2], 2'b00};
    if (ref_mem.exists(wa)) return ref_mem[wa];
    l = line_of({a[31:5], 5'b0});
    return l[a[4:2]*32 +: 32];
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  // Line memory: answers each strobe LAT negedges after it is first seen, logs every transfer.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (pmem_read && pmem_write) begin
        vectors++;
        miscompares++;
        $display("FAIL pmem_strobes: read=%b write=%b, required not both high", pmem_read, pmem_write);
      end
      if (pmem_read || pmem_write) begin
        if (wait_cnt == LAT) begin
          pmem_resp = 1'b1;
          wait_cnt  = 0;
          log_wr.push_back(pmem_write);
          log_addr.push_back(pmem_address);
          log_data.push_back(pmem_wdata);
          if (pmem_write) begin
            mem_lines[pmem_address] = pmem_wdata;
          end else begin
            pmem_rdata = line_of(pmem_address);
            n_fill++;
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the response edge with the request dropped.
  task automatic cpu_access(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] be, input string name);
    logic [31:0] exp;
    bit          done;
    int          lat;
    done            = 1'b0;
    lat             = 0;
    mem_read        = !wr;
    mem_write       = wr;
    mem_address     = addr;
    mem_wdata       = wd;
    mem_byte_enable = be;
    if (!wr) exp_q.push_back(ref_word(addr));
    else ref_mem[{addr[31:2], 2'b00}] = merge(ref_word(addr), wd, be);
    while (!done && lat <= BUDGET) begin
      #1;
      if (mem_resp) done = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    last_lat = lat;
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL %s: no mem_resp within %0d cycles", name, BUDGET);
      if (!wr) void'(exp_q.pop_front());
    end else if (!wr) begin
      exp = exp_q.pop_front();
      if (mem_rdata !== exp) begin
        miscompares++;
        $display("FAIL %s: mem_rdata=%h, required %h", name, mem_rdata, exp);
      end
    end
    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ref_mem.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vectors += 6;
    if ({mem_resp, pmem_read, pmem_write} !== 3'b000) begin
      miscompares++; $display("FAIL reset_strobes: %b, required 000", {mem_resp, pmem_read, pmem_write});
    end
    if (pmem_address !== 32'h0) begin
      miscompares++; $display("FAIL reset_pmem_address: %h, required 0", pmem_address);
    end
    if (pmem_wdata !== '0) begin
      miscompares++; $display("FAIL reset_pmem_wdata: %h, required 0", pmem_wdata);
    end
    if (mem_rdata !== 32'h0) begin
      miscompares++; $display("FAIL reset_mem_rdata: %h, required 0", mem_rdata);
    end
    if (hit_count !== 32'h0) begin
      miscompares++; $display("FAIL reset_hit_count: %0d, required 0", hit_count);
    end
    if (miss_count !== 32'h0) begin
      miscompares++; $display("FAIL reset_miss_count: %0d, required 0", miss_count);
    end
    @(negedge clk);
  endtask

  task automatic expect_lat(input int want, input string name);
    vectors++;
    if (last_lat !== want) begin
      miscompares++; $display("FAIL %s_latency: %0d cycles, required %0d", name, last_lat, want);
    end
  endtask

  task automatic expect_log(input int pos, input bit wr, input logic [31:0] addr, input string name);
    vectors++;
    if (log_wr.size() <= pos) begin
      miscompares++; $display("FAIL %s: only %0d transfers logged, required entry %0d", name, log_wr.size(), pos);
    end else if (log_wr[pos] !== wr || log_addr[pos] !== addr) begin
      miscompares++;
      $display("FAIL %s: write=%b addr=%h, required write=%b addr=%h", name, log_wr[pos], log_addr[pos], wr, addr);
    end
  endtask

  task automatic test_read_miss();
    int n0;
    n0 = log_wr.size();
    cpu_access(1'b0, 32'h0000_0040, 32'h0, 4'h0, "read_miss_40");
    expect_lat(CLEAN, "read_miss_40");
    expect_log(n0, 1'b0, 32'h0000_0040, "read_miss_40_fill");
  endtask

  task automatic test_write_hit();
    int n0;
    n0 = log_wr.size();
    cpu_access(1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 4'b0011, "write_hit_44");
    expect_lat(0, "write_hit_44");
    cpu_access(1'b0, 32'h0000_0044, 32'h0, 4'h0, "read_back_44");
    expect_lat(0, "read_back_44");
    vectors++;
    if (log_wr.size() != n0) begin
      miscompares++; $display("FAIL write_hit_traffic: %0d transfers, required 0", log_wr.size() - n0);
    end
  endtask

  task automatic test_plru();
    cpu_access(1'b0, 32'h0000_0140, 32'h0, 4'h0, "plru_fill_140");
    expect_lat(CLEAN, "plru_fill_140");
    cpu_access(1'b0, 32'h0000_0040, 32'h0, 4'h0, "plru_touch_40");
    expect_lat(0, "plru_touch_40");
    cpu_access(1'b0, 32'h0000_0240, 32'h0, 4'h0, "plru_miss_240");
    expect_lat(CLEAN, "plru_miss_240");
    cpu_access(1'b0, 32'h0000_0040, 32'h0, 4'h0, "plru_keep_40");
    expect_lat(0, "plru_keep_40");
    cpu_access(1'b0, 32'h0000_0140, 32'h0, 4'h0, "plru_gone_140");
    expect_lat(CLEAN, "plru_gone_140");
  endtask

  task automatic test_dirty_evict();
    int n0;
    logic [31:0] want;
    n0   = log_wr.size();
    want = ref_word(32'h0000_0044);
    cpu_access(1'b0, 32'h0000_0340, 32'h0, 4'h0, "dirty_miss_340");
    expect_lat(DIRTY, "dirty_miss_340");
    expect_log(n0, 1'b1, 32'h0000_0040, "dirty_writeback");
    expect_log(n0 + 1, 1'b0, 32'h0000_0340, "dirty_fill");
    vectors++;
    if (log_data.size() <= n0 || log_data[n0][63:32] !== want) begin
      miscompares++;
      $display("FAIL dirty_wdata: word1=%h, required %h", (log_data.size() > n0) ? log_data[n0][63:32] : 32'hx, want);
    end
    cpu_access(1'b0, 32'h0000_0044, 32'h0, 4'h0, "refetch_44");
    expect_lat(CLEAN, "refetch_44");
  endtask

  task automatic test_reset_mid_fill();
    int  n0;
    bit  seen;
    seen        = 1'b0;
    n0          = log_wr.size();
    mem_read    = 1'b1;
    mem_address = 32'h0000_0080;
    for (int i = 0; i < BUDGET && !seen; i++) begin
      @(negedge clk);
      #1;
      seen = pmem_read;
    end
    vectors++;
    if (!seen) begin
      miscompares++; $display("FAIL midfill_start: pmem_read=%b, required 1", pmem_read);
    end
    rst      = 1'b1;
    mem_read = 1'b0;
    @(negedge clk);
    #1;
    vectors += 2;
    if ({pmem_read, pmem_write} !== 2'b00) begin
      miscompares++; $display("FAIL midfill_strobes: %b, required 00", {pmem_read, pmem_write});
    end
    if (log_wr.size() != n0) begin
      miscompares++; $display("FAIL midfill_transfer: %0d transfers, required 0", log_wr.size() - n0);
    end
    rst = 1'b0;
    ref_mem.delete();
    exp_q.delete();
    @(negedge clk);
    cpu_access(1'b0, 32'h0000_0080, 32'h0, 4'h0, "after_reset_80");
    expect_lat(CLEAN, "after_reset_80");
    cpu_access(1'b0, 32'h0000_0044, 32'h0, 4'h0, "after_reset_44");
    expect_lat(CLEAN, "after_reset_44");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    for (int i = 0; i < 8; i++) begin
      a = 32'h0000_0080 + 32'(4 * i);
      cpu_access(1'b1, a, $urandom, 4'($urandom_range(1, 15)), "b2b_write");
      expect_lat(0, "b2b_write");
      cpu_access(1'b0, a, 32'h0, 4'h0, "b2b_read");
      expect_lat(0, "b2b_read");
    end
  endtask

  task automatic test_perf_counters();
    logic [31:0] want_hit, want_miss;
`ifdef ASSOC_CACHE_PERF_CNT_EN
    want_hit  = 32'd3;
    want_miss = 32'd2;
`else
    want_hit  = 32'd0;
    want_miss = 32'd0;
`endif
    do_reset();
    cpu_access(1'b0, 32'h0000_0400, 32'h0, 4'h0, "perf_miss_400");
    cpu_access(1'b0, 32'h0000_0404, 32'h0, 4'h0, "perf_hit_404");
    cpu_access(1'b1, 32'h0000_0408, 32'h1234_5678, 4'hF, "perf_hit_408");
    cpu_access(1'b0, 32'h0000_0500, 32'h0, 4'h0, "perf_miss_500");
    cpu_access(1'b0, 32'h0000_0408, 32'h0, 4'h0, "perf_hit_408r");
    #1;
    vectors += 2;
    if (hit_count !== want_hit) begin
      miscompares++; $display("FAIL hit_count: %0d, required %0d", hit_count, want_hit);
    end
    if (miss_count !== want_miss) begin
      miscompares++; $display("FAIL miss_count: %0d, required %0d", miss_count, want_miss);
    end
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_write_hit();
    test_plru();
    test_dirty_evict();
    test_reset_mid_fill();
    test_back_to_back();
    test_perf_counters();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
